conv_rmst_arbiter: RTL
======================

# conv_rmst_arbiter

Two-requester arbiter for the single Avalon read master that feeds the conv pipeline. It shares one `rmst_*` port pair between the weight-prefetch stream (requester 0) and the feature-map stream (requester 1). Each grant carries one complete read transaction: launch, beat forwarding, and drain of the master's read FIFO. Only after that transaction ends is the master handed to the other requester. The block sits between the read-side memory block and the external read master.

## Interface
Parameters:
- AW, 30, address/length width in bytes
- DW, 128, read data width; one beat = DW/8 bytes

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  transaction request; held high until the matching gnt is seen
- base0 / base1  in  AW  byte start address; sampled in the grant cycle
- len0 / len1  in  AW  byte length; sampled in the grant cycle
- fixed0 / fixed1  in  1  fixed-location flag; sampled in the grant cycle
- gnt0 / gnt1  out  1  owner indication, high from LAUNCH through RELEASE
- done0 / done1  out  1  one-cycle completion pulse to the owner
- rd0 / rd1  in  1  owner's read strobe (read_buffer)
- avail0 / avail1  out  1  data available, routed to the owner only
- rdata  out  DW  equal to `rmst_user_buffer_data`; shared by both requesters
- busy  out  1  high whenever state is not IDLE
- rmst_ctrl_fixed_location  out  1  latched fixed flag
- rmst_ctrl_read_base  out  AW  latched base
- rmst_ctrl_read_length  out  AW  latched length
- rmst_ctrl_go  out  1  one-cycle launch pulse
- rmst_ctrl_done  in  1  master done
- rmst_user_read_buffer  out  1  forwarded owner read strobe
- rmst_user_buffer_data  in  DW  master FIFO data
- rmst_user_data_available  in  1  master FIFO not empty

## Operation
States: IDLE, LAUNCH, BUSY, DRAIN, RELEASE, ZERO.

- **IDLE**
  - If a request is present, pick the winner round-robin: the requester that was not granted last wins when both ask.
  - Latch the owner index and the winner's base, len and fixed.
  - If the latched len = 0, go to ZERO; otherwise go to LAUNCH.
- **LAUNCH**
  - `rmst_ctrl_go` = 1 for exactly this cycle.
  - gnt(owner) = 1.
  - Next state: BUSY.
- **BUSY**
  - `rmst_user_read_buffer` = rd(owner); avail(owner) = `rmst_user_data_available`.
  - The non-owner's avail is 0 and its rd is ignored.
  - `rmst_ctrl_done` = 1 moves to DRAIN.
- **DRAIN**
  - Routing is the same as in BUSY.
  - When `rmst_user_data_available` = 0 and no read is pending this cycle, go to RELEASE.
- **RELEASE**
  - done(owner) = 1 for one cycle; gnt stays high this cycle.
  - Record the last-grant pointer = owner.
  - Next state: IDLE.
- **ZERO**
  - No go pulse is issued.
  - gnt(owner) = 1 and done(owner) = 1 in the same cycle.
  - Update the last-grant pointer.
  - Next state: IDLE.

Rules that apply in every state:
- Deasserting req after the grant has no effect; the transaction always completes.
- A new req from the current owner is not considered until IDLE.
- The `rmst_ctrl_*` address/length/fixed outputs hold their latched values until the next grant.
- A beat counter counts `rmst_user_read_buffer` & `rmst_user_data_available` events modulo 2^AW. It is cleared in LAUNCH and used only for verification visibility; it has no output port.

## Timing
Reset values (asynchronous):
- state = IDLE.
- Last-grant pointer = 1, so requester 0 wins the first contention.
- All outputs are 0: gnt, done, avail, go, read_buffer, base, length, fixed, busy.

Latency and sequencing:
- req sampled high at edge n (IDLE) gives LAUNCH in cycle n+1, with gnt and go high.
- BUSY starts at n+2.
- After RELEASE, the state is IDLE for at least one cycle. The earliest next grant is sampled at the edge ending that IDLE cycle, so the minimum dead time between transactions is 2 cycles (RELEASE plus IDLE).
- `rmst_ctrl_done` arriving while data is still buffered must not release the master; data remaining after done is delivered to the same owner.
- `rmst_ctrl_done` and the last data beat in the same cycle: DRAIN waits one cycle for the available signal to fall.
- Reset asserted mid-transaction returns to IDLE immediately with all outputs 0, and no done pulse is issued.
- avail, rd, read_buffer and rdata are pure combinational forwards, with zero added latency.

## Test plan
- **Single transaction:** req0 with base0 = 0x1000, len0 = 64 (DW = 128, 4 beats).
  - go pulses once, with read_base = 0x1000 and read_length = 64.
  - 4 beats reach rdata/avail0; avail1 stays 0.
  - done0 pulses once after FIFO empty.
- **Contention:** req0 and req1 rise in the same cycle after reset.
  - Requester 0 is served first, then requester 1.
  - A repeat of both requests then serves 0 first again (pointer = 1 after serving 1).
- **Starvation check:** req1 is held while req0 re-requests immediately after done0.
  - Requester 1 is granted next.
- **Zero length:** len1 = 0.
  - No go pulse.
  - gnt1 and done1 are high in the same single cycle.
  - busy returns to 0 the next cycle.
- **Drain:** rmst_ctrl_done asserts while 3 beats remain buffered.
  - The arbiter stays in DRAIN until all 3 beats are read by the owner, then pulses done.
  - A pending req from the other requester waits throughout.
- **Reset mid-BUSY:** rst pulses after 2 of 4 beats.
  - All outputs are 0 asynchronously and no done pulse is issued.
  - After reset, req1 alone is granted normally.

Source files
------------

// File: rtl/conv_rmst_arbiter_if.sv
// Bundle of requester-side and read-master-side signals around conv_rmst_arbiter.
// The arbiter takes the "master" modport because it drives the rmst_ctrl/user port.
interface conv_rmst_arbiter_if #(
  parameter int AW = 30,
  parameter int DW = 128
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] base0;
  logic [AW-1:0] base1;
  logic [AW-1:0] len0;
  logic [AW-1:0] len1;
  logic          fixed0;
  logic          fixed1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic          rd0;
  logic          rd1;
  logic          avail0;
  logic          avail1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          rmst_ctrl_fixed_location;
  logic [AW-1:0] rmst_ctrl_read_base;
  logic [AW-1:0] rmst_ctrl_read_length;
  logic          rmst_ctrl_go;
  logic          rmst_ctrl_done;
  logic          rmst_user_read_buffer;
  logic [DW-1:0] rmst_user_buffer_data;
  logic          rmst_user_data_available;

  modport master (
    input  req0, req1, base0, base1, len0, len1, fixed0, fixed1, rd0, rd1,
    input  rmst_ctrl_done, rmst_user_buffer_data, rmst_user_data_available,
    output gnt0, gnt1, done0, done1, avail0, avail1, rdata, busy,
    output rmst_ctrl_fixed_location, rmst_ctrl_read_base, rmst_ctrl_read_length,
    output rmst_ctrl_go, rmst_user_read_buffer
  );

  modport slave (
    output req0, req1, base0, base1, len0, len1, fixed0, fixed1, rd0, rd1,
    output rmst_ctrl_done, rmst_user_buffer_data, rmst_user_data_available,
    input  gnt0, gnt1, done0, done1, avail0, avail1, rdata, busy,
    input  rmst_ctrl_fixed_location, rmst_ctrl_read_base, rmst_ctrl_read_length,
    input  rmst_ctrl_go, rmst_user_read_buffer
  );
endinterface

// File: rtl/conv_rmst_arbiter.sv
// Round-robin sharing of one Avalon read master between the weight-prefetch (0)
// and feature-map (1) streams; each grant spans launch, beat forwarding and FIFO drain.
module conv_rmst_arbiter #(
  parameter int AW = 30,
  parameter int DW = 128
) (
  input  logic                clk,
  input  logic                rst,
  conv_rmst_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_BUSY    = 3'd2,
    S_DRAIN   = 3'd3,
    S_RELEASE = 3'd4,
    S_ZERO    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          fixed_q, fixed_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] beat_cnt_q, beat_cnt_d;

  logic active_s;
  logic route_s;
  logic finish_s;
  logic rd_owner_s;
  logic read_buf_s;
  logic winner_s;

  assign active_s   = (state_q != S_IDLE);
  assign route_s    = (state_q == S_BUSY) || (state_q == S_DRAIN);
  assign finish_s   = (state_q == S_RELEASE) || (state_q == S_ZERO);
  assign rd_owner_s = owner_q ? bus.rd1 : bus.rd0;
  assign read_buf_s = route_s & rd_owner_s;
  // With both asking, whoever was not served last takes the master.
  assign winner_s   = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    fixed_d    = fixed_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q + AW'(read_buf_s & bus.rmst_user_data_available);
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          owner_d = winner_s;
          base_d  = winner_s ? bus.base1  : bus.base0;
          len_d   = winner_s ? bus.len1   : bus.len0;
          fixed_d = winner_s ? bus.fixed1 : bus.fixed0;
          state_d = (len_d == '0) ? S_ZERO : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        beat_cnt_d = '0;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        if (bus.rmst_ctrl_done) state_d = S_DRAIN;
      end
      // Master done alone is not enough: buffered beats still belong to this owner.
      S_DRAIN: begin
        if (!bus.rmst_user_data_available && !rd_owner_s) state_d = S_RELEASE;
      end
      S_RELEASE, S_ZERO: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      fixed_q    <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      fixed_q    <= fixed_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.gnt0   = active_s & ~owner_q;
  assign bus.gnt1   = active_s & owner_q;
  assign bus.done0  = finish_s & ~owner_q;
  assign bus.done1  = finish_s & owner_q;
  assign bus.avail0 = route_s & ~owner_q & bus.rmst_user_data_available;
  assign bus.avail1 = route_s & owner_q & bus.rmst_user_data_available;
  assign bus.rdata  = bus.rmst_user_buffer_data;
  assign bus.busy   = active_s;

  assign bus.rmst_ctrl_fixed_location = fixed_q;
  assign bus.rmst_ctrl_read_base      = base_q;
  assign bus.rmst_ctrl_read_length    = len_q;
  assign bus.rmst_ctrl_go             = (state_q == S_LAUNCH);
  assign bus.rmst_user_read_buffer    = read_buf_s;

endmodule
